// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch front end.
package fetch_pkg;

    localparam int DW = 32;
    localparam int AW = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
        logic          filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// Slot ring with separate reserve (alloc), data-return (fill) and consume (head) pointers.
module fetch_ring #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_alloc,
    input  logic [fetch_pkg::AW-1:0]     i_alloc_pc,
    input  logic                         i_fill,
    input  logic [fetch_pkg::DW-1:0]     i_fill_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [$clog2(DEPTH):0]       o_occ,
    output logic [$clog2(DEPTH):0]       o_inflight,
    output fetch_pkg::fetch_entry_t      o_head
);
    import fetch_pkg::*;

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t r_slot [DEPTH];
    logic [PW:0]  r_alloc_ptr;
    logic [PW:0]  r_fill_ptr;
    logic [PW:0]  r_head_ptr;

    logic [PW-1:0] w_alloc_idx;
    logic [PW-1:0] w_fill_idx;
    logic [PW-1:0] w_head_idx;

    assign w_alloc_idx = r_alloc_ptr[PW-1:0];
    assign w_fill_idx  = r_fill_ptr[PW-1:0];
    assign w_head_idx  = r_head_ptr[PW-1:0];

    assign o_occ      = r_alloc_ptr - r_head_ptr;
    assign o_inflight = r_alloc_ptr - r_fill_ptr;
    assign o_head     = r_slot[w_head_idx];

    // Pop, alloc and fill never target the same slot field in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else if (i_flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i].filled <= 1'b0;
            end
        end else begin
            if (i_pop) begin
                r_slot[w_head_idx].filled <= 1'b0;
                r_head_ptr <= r_head_ptr + (PW+1)'(1);
            end
            if (i_alloc) begin
                r_slot[w_alloc_idx].pc     <= i_alloc_pc;
                r_slot[w_alloc_idx].filled <= 1'b0;
                r_alloc_ptr <= r_alloc_ptr + (PW+1)'(1);
            end
            if (i_fill) begin
                r_slot[w_fill_idx].data   <= i_fill_data;
                r_slot[w_fill_idx].filled <= 1'b1;
                r_fill_ptr <= r_fill_ptr + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch stage: sequential PC generation, in-order imem requests,
// show-ahead instruction queue and redirect flush with stale-response dropping.
module fetch_queue #(
    parameter int             DW       = fetch_pkg::DW,
    parameter int             AW       = fetch_pkg::AW,
    parameter int             DEPTH    = 4,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_i,
    input  logic [AW-1:0] redirect_pc_i,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [DW-1:0] imem_rdata_i,
    output logic          instr_valid_o,
    output logic [DW-1:0] instr_o,
    output logic [AW-1:0] pc_o,
    input  logic          instr_ready_i
);
    import fetch_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] r_pc;
    logic [PW:0]   r_drop_cnt;

    logic [PW:0]   w_occ;
    logic [PW:0]   w_inflight;
    logic [PW+1:0] w_pending;
    fetch_entry_t  w_head;
    logic          w_grant;
    logic          w_pop;
    logic          w_drop_rsp;
    logic          w_fill;

    fetch_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .i_alloc     (w_grant),
        .i_alloc_pc  (r_pc),
        .i_fill      (w_fill),
        .i_fill_data (imem_rdata_i),
        .i_pop       (w_pop),
        .i_flush     (redirect_i),
        .o_occ       (w_occ),
        .o_inflight  (w_inflight),
        .o_head      (w_head)
    );

    // Reserved slots plus responses still owed to a flushed stream cap new requests.
    assign w_pending  = {1'b0, w_occ} + {1'b0, r_drop_cnt};
    assign imem_req_o = rst && !redirect_i && (w_pending < (PW+2)'(DEPTH));
    assign imem_addr_o = r_pc;
    assign w_grant    = imem_req_o && imem_gnt_i;

    assign w_drop_rsp = imem_rvalid_i && (r_drop_cnt != '0);
    assign w_fill     = imem_rvalid_i && !w_drop_rsp && !redirect_i
                        && (w_inflight != '0);

    assign instr_valid_o = w_head.filled && (w_occ != '0) && !redirect_i;
    assign w_pop         = instr_valid_o && instr_ready_i;
    assign instr_o       = instr_valid_o ? DW'(w_head.data) : DW'(NOP_INSTR);
    assign pc_o          = instr_valid_o ? AW'(w_head.pc) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect_i) begin
            r_pc       <= {redirect_pc_i[AW-1:2], 2'b00};
            r_drop_cnt <= r_drop_cnt + w_inflight
                          - {{PW{1'b0}}, imem_rvalid_i};
        end else begin
            if (w_grant) begin
                r_pc <= r_pc + AW'(PC_INC);
            end
            if (w_drop_rsp) begin
                r_drop_cnt <= r_drop_cnt - (PW+1)'(1);
            end
        end
    end

    rvalid_has_owner: assert property (
        @(posedge clk) disable iff (!rst)
        imem_rvalid_i |-> (r_drop_cnt != '0 || w_inflight != '0)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-level reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    fetch_queue #(
        .DW       (32),
        .AW       (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ent_t  m_q[$];
    mreq_t mem_q[$];
    logic [31:0] m_pc;
    int    m_drop;

    int n_vec;
    int n_err;
    int cyc;

    int p_gnt, p_rdy, p_redir, lat_min, lat_max;
    bit force_redir;
    logic [31:0] force_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        mem_q.delete();
        m_pc   = 32'h0;
        m_drop = 0;
    endtask

    task automatic step();
        bit exp_req, exp_valid, grant, pop, done;
        int unf;
        @(negedge clk);
        cyc++;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0].addr);
            mem_q.delete(0);
        end
        imem_gnt_i    = ($urandom_range(99) < p_gnt);
        instr_ready_i = ($urandom_range(99) < p_rdy);
        redirect_i    = force_redir || ($urandom_range(999) < p_redir);
        redirect_pc_i = force_redir ? force_pc : $urandom;
        force_redir   = 1'b0;

        exp_req   = !redirect_i && ((m_q.size() + m_drop) < DEPTH);
        exp_valid = !redirect_i && m_q.size() > 0 && m_q[0].filled;

        #1;
        chk("req", imem_req_o, exp_req);
        if (exp_req) chk("addr", imem_addr_o, m_pc);
        chk("valid", instr_valid_o, exp_valid);
        if (exp_valid) begin
            chk("pc", pc_o, m_q[0].pc);
            chk("instr", instr_o, m_q[0].data);
            chk("instr_vs_mem", instr_o, mem_word(m_q[0].pc));
        end else if (!redirect_i) begin
            chk("idle_instr", instr_o, NOP);
            chk("idle_pc", pc_o, 32'h0);
        end

        grant = exp_req && imem_gnt_i;
        pop   = exp_valid && instr_ready_i;
        if (grant) begin
            mem_q.push_back('{addr: m_pc,
                              due: cyc + int'($urandom_range(lat_max, lat_min))});
        end

        if (redirect_i) begin
            unf = 0;
            foreach (m_q[i]) if (!m_q[i].filled) unf++;
            m_drop = m_drop + unf - (imem_rvalid_i ? 1 : 0);
            m_q.delete();
            m_pc = redirect_pc_i & ~32'h3;
        end else begin
            if (imem_rvalid_i) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    done = 1'b0;
                    foreach (m_q[i]) begin
                        if (!done && !m_q[i].filled) begin
                            m_q[i].data   = imem_rdata_i;
                            m_q[i].filled = 1'b1;
                            done = 1'b1;
                        end
                    end
                end
            end
            if (pop) m_q.delete(0);
            if (grant) begin
                m_q.push_back('{pc: m_pc, data: 32'h0, filled: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic knobs(input int g, input int r, input int rd,
                         input int lmin, input int lmax);
        p_gnt = g; p_rdy = r; p_redir = rd; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic idle_inputs();
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        instr_ready_i = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        force_redir = 1'b0;
        force_pc    = 32'h0;
        knobs(100, 100, 0, 1, 1);
        idle_inputs();
        model_reset();
        rst = 1'b0;
        #3;
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc", pc_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // streaming with a 1-cycle memory
        run(20);
        // decode stalled: queue fills, then drains
        knobs(100, 0, 0, 1, 1);
        run(10);
        knobs(100, 100, 0, 1, 1);
        run(6);
        // redirect with responses still in flight
        knobs(100, 100, 0, 3, 3);
        run(3);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0103;
        run(15);
        // redirect coinciding with response and pop
        knobs(100, 100, 0, 1, 1);
        run(8);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0200;
        run(10);
        // address wrap
        force_redir = 1'b1;
        force_pc    = 32'hFFFF_FFFC;
        run(10);
        // back-to-back redirects
        knobs(100, 100, 0, 2, 4);
        run(4);
        force_redir = 1'b1;
        force_pc    = 32'h0000_1000;
        step();
        force_redir = 1'b1;
        force_pc    = 32'h0000_2000;
        run(20);
        // random mix
        knobs(70, 60, 30, 1, 4);
        run(3000);

        // reset pulse while full
        knobs(100, 0, 0, 1, 1);
        run(10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_req", imem_req_o, 1'b0);
        chk("midrst_valid", instr_valid_o, 1'b0);
        chk("midrst_instr", instr_o, NOP);
        chk("midrst_pc", pc_o, 32'h0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        knobs(100, 100, 0, 1, 1);
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
